// File: rtl/vx_barrier_ctrl_pkg.sv
// Shared GPU types for the warp barrier controller: sizing, request/release
// structs and a warp-id to one-hot helper.
package vx_barrier_ctrl_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 4;
  localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  typedef struct packed {
    logic               valid;
    logic [NB_BITS-1:0] id;
    logic [NW_BITS-1:0] size_m1;
  } gpu_barrier_t;

  localparam int GPU_BARRIER_BITS = $bits(gpu_barrier_t);

  typedef struct packed {
    logic                 valid;
    logic [NUM_WARPS-1:0] wmask;
  } gpu_barrier_rel_t;

  localparam int GPU_BARRIER_REL_BITS = $bits(gpu_barrier_rel_t);

  function automatic logic [NUM_WARPS-1:0] wid_to_mask(input logic [NW_BITS-1:0] wid);
    return NUM_WARPS'(1) << wid;
  endfunction

endpackage

// File: rtl/vx_barrier_ctrl_entry.sv
// One barrier ID: membership mask, member count (members-1) and busy flag.
// 'last' is combinational so the top can build the release in the same cycle.
module vx_barrier_ctrl_entry
  import vx_barrier_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive,
  input  logic [NW_BITS-1:0]   wid,
  input  logic [NW_BITS-1:0]   size_m1,
  output logic                 last,
  output logic [NUM_WARPS-1:0] mask,
  output logic                 busy
);

  logic [NUM_WARPS-1:0] mask_q, mask_d;
  logic [NW_BITS-1:0]   cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [NW_BITS:0]     cnt_inc;

  // Extra bit keeps cnt+1 from wrapping back onto a small size_m1.
  assign cnt_inc = {1'b0, cnt_q} + {{NW_BITS{1'b0}}, 1'b1};
  assign last    = busy_q ? (cnt_inc == {1'b0, size_m1}) : (size_m1 == '0);
  assign mask    = mask_q;
  assign busy    = busy_q;

  // Next membership: the completing arrival empties the entry, others join it.
  always_comb begin
    mask_d = mask_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (arrive) begin
      if (last) begin
        mask_d = '0;
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        mask_d = mask_q | wid_to_mask(wid);
        cnt_d  = busy_q ? cnt_inc[NW_BITS-1:0] : '0;
        busy_d = 1'b1;
      end
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/vx_barrier_ctrl.sv
// Warp barrier scheduler: parks arriving warps per barrier ID and hands the
// complete group to the scheduler through a 1-deep release register.
module vx_barrier_ctrl
  import vx_barrier_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [NW_BITS-1:0]          req_wid,
  input  logic [GPU_BARRIER_BITS-1:0] req_barrier,
  output logic                        rel_valid,
  input  logic                        rel_ready,
  output logic [NUM_WARPS-1:0]        rel_wmask,
  output logic [NUM_WARPS-1:0]        stalled_wmask,
  output logic [NUM_BARRIERS-1:0]     busy,
  output logic                        err_dup
);

  gpu_barrier_t         bar;
  logic                 bar_valid_unused;
  logic                 fire, dup, accept, last_sel;
  logic [NUM_WARPS-1:0] mask_sel, stalled;
  logic                 entry_last [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] entry_mask [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] entry_busy;
  gpu_barrier_rel_t     rel_q, rel_d;
  logic                 err_dup_q;

  assign bar              = gpu_barrier_t'(req_barrier);
  assign bar_valid_unused = bar.valid;

  // The release slot must be able to drain before another request is taken.
  assign req_ready = !rel_q.valid || rel_ready;
  assign fire      = req_valid && req_ready;
  // A warp parked anywhere is a duplicate regardless of the requested ID.
  assign dup       = |(stalled & wid_to_mask(req_wid));
  assign accept    = fire && !dup;
  assign last_sel  = entry_last[bar.id];
  assign mask_sel  = entry_mask[bar.id];

  for (genvar i = 0; i < NUM_BARRIERS; i++) begin : g_entry
    vx_barrier_ctrl_entry u_entry (
      .clk     (clk),
      .reset   (reset),
      .arrive  (accept && (bar.id == NB_BITS'(i))),
      .wid     (req_wid),
      .size_m1 (bar.size_m1),
      .last    (entry_last[i]),
      .mask    (entry_mask[i]),
      .busy    (entry_busy[i])
    );
  end

  // Parked warps are the union of all entry masks (entry registers only).
  always_comb begin
    stalled = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) stalled = stalled | entry_mask[i];
  end

  // Release slot: a new group overwrites a slot that is draining this cycle.
  always_comb begin
    rel_d = rel_q;
    if (accept && last_sel) begin
      rel_d.valid = 1'b1;
      rel_d.wmask = mask_sel | wid_to_mask(req_wid);
    end else if (rel_ready) begin
      rel_d = '0;
    end
  end

  // Release register and duplicate pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rel_q     <= '0;
      err_dup_q <= 1'b0;
    end else begin
      rel_q     <= rel_d;
      err_dup_q <= fire && dup;
    end
  end

  assign rel_valid     = rel_q.valid;
  assign rel_wmask     = rel_q.wmask;
  assign stalled_wmask = stalled;
  assign busy          = entry_busy;
  assign err_dup       = err_dup_q;

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Bench for vx_barrier_ctrl: directed scenarios with literal expectations,
// then random traffic, all compared each cycle against a group-level model.
module tb_vx_barrier_ctrl;
  import vx_barrier_ctrl_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        req_valid = 1'b0;
  logic                        req_ready;
  logic [NW_BITS-1:0]          req_wid = '0;
  logic [GPU_BARRIER_BITS-1:0] req_barrier = '0;
  logic                        rel_valid;
  logic                        rel_ready = 1'b1;
  logic [NUM_WARPS-1:0]        rel_wmask;
  logic [NUM_WARPS-1:0]        stalled_wmask;
  logic [NUM_BARRIERS-1:0]     busy;
  logic                        err_dup;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_barrier_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wid       (req_wid),
    .req_barrier   (req_barrier),
    .rel_valid     (rel_valid),
    .rel_ready     (rel_ready),
    .rel_wmask     (rel_wmask),
    .stalled_wmask (stalled_wmask),
    .busy          (busy),
    .err_dup       (err_dup)
  );

  // Model: each barrier is a set of waiting warps; a group completes when the
  // arrival finds size_m1 warps already waiting.
  logic [NUM_WARPS-1:0] m_mask [NUM_BARRIERS];
  logic                 m_rel_v;
  logic [NUM_WARPS-1:0] m_rel_m;
  logic                 m_err;

  function automatic logic [NUM_WARPS-1:0] m_stalled();
    logic [NUM_WARPS-1:0] s = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) s = s | m_mask[i];
    return s;
  endfunction

  function automatic logic [NUM_BARRIERS-1:0] m_busy();
    logic [NUM_BARRIERS-1:0] b = '0;
    for (int i = 0; i < NUM_BARRIERS; i++) b[i] = (m_mask[i] != '0);
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    gpu_barrier_t         rq;
    logic [NUM_WARPS-1:0] nm [NUM_BARRIERS];
    logic                 nv, ne;
    logic [NUM_WARPS-1:0] nr;
    int                   members, w, b;
    if (reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) m_mask[i] <= '0;
      m_rel_v <= 1'b0;
      m_rel_m <= '0;
      m_err   <= 1'b0;
    end else begin
      rq = gpu_barrier_t'(req_barrier);
      for (int i = 0; i < NUM_BARRIERS; i++) nm[i] = m_mask[i];
      nv = m_rel_v && !rel_ready;
      nr = m_rel_m;
      ne = 1'b0;
      w  = int'(req_wid);
      b  = int'(rq.id);
      if (req_valid && (!m_rel_v || rel_ready)) begin
        if (m_stalled()[w]) begin
          ne = 1'b1;
        end else begin
          members = $countones(m_mask[b]);
          if (members == int'(rq.size_m1)) begin
            nr = m_mask[b];
            nr[w] = 1'b1;
            nv = 1'b1;
            nm[b] = '0;
          end else begin
            nm[b][w] = 1'b1;
          end
        end
      end
      for (int i = 0; i < NUM_BARRIERS; i++) m_mask[i] <= nm[i];
      m_rel_v <= nv;
      m_rel_m <= nr;
      m_err   <= ne;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("req_ready", int'(req_ready), int'(!m_rel_v || rel_ready));
      chk("rel_valid", int'(rel_valid), int'(m_rel_v));
      if (m_rel_v) chk("rel_wmask", int'(rel_wmask), int'(m_rel_m));
      chk("stalled_wmask", int'(stalled_wmask), int'(m_stalled()));
      chk("busy", int'(busy), int'(m_busy()));
      chk("err_dup", int'(err_dup), int'(m_err));
    end
  end

  // Drive one cycle of inputs just after an edge, return just after the next.
  task automatic step(input logic v, input int w, input int id, input int sz, input logic rr);
    gpu_barrier_t rq;
    rq.valid   = v;
    rq.id      = NB_BITS'(id);
    rq.size_m1 = NW_BITS'(sz);
    req_valid   = v;
    req_wid     = NW_BITS'(w);
    req_barrier = rq;
    rel_ready   = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 0, 0, 0, rr);
  endtask

  initial begin
    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rel_valid", int'(rel_valid), 0);
    chk("rst_stalled", int'(stalled_wmask), 'h0);
    chk("rst_busy", int'(busy), 'h0);
    chk("rst_req_ready", int'(req_ready), 1);

    // 2: three-warp group on ID1
    step(1'b1, 0, 1, 2, 1'b1);
    step(1'b1, 2, 1, 2, 1'b1);
    chk("grp_stalled", int'(stalled_wmask), 'b0101);
    chk("grp_busy", int'(busy), 'b0010);
    step(1'b1, 3, 1, 2, 1'b1);
    chk("grp_rel_valid", int'(rel_valid), 1);
    chk("grp_rel_wmask", int'(rel_wmask), 'b1101);
    chk("grp_stalled_clr", int'(stalled_wmask), 'h0);
    chk("grp_busy_clr", int'(busy), 'h0);

    // 3: single-warp barrier releases immediately
    step(1'b1, 1, 0, 0, 1'b1);
    chk("solo_rel_wmask", int'(rel_wmask), 'b0010);
    chk("solo_stalled", int'(stalled_wmask), 'h0);
    idle(1'b1);

    // 4: backpressure, then back-to-back release
    step(1'b1, 0, 2, 1, 1'b1);
    step(1'b1, 1, 3, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2, 2, 1, 1'b0);
      chk("bp_req_ready", int'(req_ready), 0);
      chk("bp_rel_wmask", int'(rel_wmask), 'b0010);
    end
    step(1'b1, 2, 2, 1, 1'b1);
    chk("b2b_rel_valid", int'(rel_valid), 1);
    chk("b2b_rel_wmask", int'(rel_wmask), 'b0101);
    idle(1'b1);
    chk("drain_rel_valid", int'(rel_valid), 0);

    // 5: duplicates leave membership and count untouched
    step(1'b1, 0, 1, 2, 1'b1);
    step(1'b1, 0, 1, 2, 1'b1);
    chk("dup_same_err", int'(err_dup), 1);
    chk("dup_same_stalled", int'(stalled_wmask), 'b0001);
    step(1'b1, 0, 3, 1, 1'b1);
    chk("dup_other_err", int'(err_dup), 1);
    chk("dup_other_busy", int'(busy), 'b0010);
    idle(1'b1);
    chk("dup_pulse_end", int'(err_dup), 0);
    step(1'b1, 1, 1, 2, 1'b1);
    chk("dup_cnt_kept", int'(rel_valid), 0);
    step(1'b1, 2, 1, 2, 1'b1);
    chk("dup_rel_wmask", int'(rel_wmask), 'b0111);
    idle(1'b1);

    // 6: async reset mid-cycle with members parked and a release pending
    step(1'b1, 0, 0, 3, 1'b1);
    step(1'b1, 1, 0, 3, 1'b1);
    step(1'b1, 2, 3, 0, 1'b0);
    chk("pre_rst_busy", int'(busy), 'b0001);
    #2 reset = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("arst_rel_valid", int'(rel_valid), 0);
    chk("arst_stalled", int'(stalled_wmask), 'h0);
    chk("arst_busy", int'(busy), 'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 0, 0, 1, 1'b1);
    step(1'b1, 3, 0, 1, 1'b1);
    chk("post_rst_rel_wmask", int'(rel_wmask), 'b1001);
    chk("post_rst_rel_valid", int'(rel_valid), 1);

    // Random traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 3) != 0),
           int'($urandom_range(0, NUM_WARPS - 1)),
           int'($urandom_range(0, NUM_BARRIERS - 1)),
           int'($urandom_range(0, NUM_WARPS - 1)),
           ($urandom_range(0, 9) < 7));
    end
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
